// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for alu_pipe and alu_core.
// Build option ALU_MULT_EN turns opcode F from PASS A into an unsigned multiply.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_ROL = 4'h8,
    OP_ROR = 4'h9,
    OP_INC = 4'hA,
    OP_DEC = 4'hB,
    OP_MIN = 4'hC,
    OP_MAX = 4'hD,
    OP_EQ  = 4'hE,
`ifdef ALU_MULT_EN
    OP_MUL = 4'hF
`else
    OP_PASS = 4'hF
`endif
  } opcode_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } flags_t;

  localparam flags_t FLAGS_CLR = '0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: (a, b, op) -> (result, flags).
// With ALU_MULT_EN defined, opcode F multiplies; otherwise it passes A through.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  opcode_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic [WIDTH:0]   sum;
`ifdef ALU_MULT_EN
  logic [2*WIDTH-1:0] prod;
`endif

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    sum   = '0;
`ifdef ALU_MULT_EN
    prod  = '0;
`endif
    case (op_i)
      OP_ADD: begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow (a < b).
        sum   = {1'b0, a_i} - {1'b0, b_i};
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_NOT: res = ~a_i;
      OP_SHL: begin
        res   = {a_i[MSB-1:0], 1'b0};
        carry = a_i[MSB];
      end
      OP_SHR: begin
        res   = {1'b0, a_i[MSB:1]};
        carry = a_i[0];
      end
      OP_ROL: begin
        res   = {a_i[MSB-1:0], a_i[MSB]};
        carry = a_i[MSB];
      end
      OP_ROR: begin
        res   = {a_i[0], a_i[MSB:1]};
        carry = a_i[0];
      end
      OP_INC: begin
        sum   = {1'b0, a_i} + ONE;
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i == {1'b0, {(WIDTH-1){1'b1}}});
      end
      OP_DEC: begin
        sum   = {1'b0, a_i} - ONE;
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_MIN: res = (a_i < b_i) ? a_i : b_i;
      OP_MAX: res = (a_i > b_i) ? a_i : b_i;
      OP_EQ:  res = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
`ifdef ALU_MULT_EN
      OP_MUL: begin
        prod  = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        res   = prod[WIDTH-1:0];
        carry = |prod[2*WIDTH-1:WIDTH];
      end
`else
      OP_PASS: res = a_i;
`endif
      default: res = '0;
    endcase
  end

  assign result_o         = res;
  assign flags_o.carry    = carry;
  assign flags_o.zero     = (res == '0);
  assign flags_o.overflow = ovf;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU: S1 registers operands, S2 registers results.
// Build option ALU_MULT_EN selects MUL for opcode F (see alu_core).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] selection,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow
);

  // Handshake: a beat moves on a port only in a cycle where both valid and
  // ready are high. The whole pipe advances together when the output slot is
  // empty or being drained (adv), so in_ready never depends on in_valid.
  logic adv;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (opcode_e'(sel_q)),
    .result_o (core_result),
    .flags_o  (core_flags)
  );

  assign adv = !out_valid_q || out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      a_d         = a;
      b_d         = b;
      sel_d       = selection;
      out_valid_d = s1_valid_q;
      result_d    = core_result;
      flags_d     = core_flags;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= FLAGS_CLR;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = flags_q.carry;
  assign zero      = flags_q.zero;
  assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic
// checked against an arithmetic reference model through an expected queue.
module tb_alu_pipe;

  localparam int W = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   selection = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         overflow;

  alu_pipe #(.WIDTH(W), .SEL_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .selection (selection),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow)
  );

  // scoreboard: {carry, zero, overflow, result}
  logic [W+2:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int out_cnt = 0;

  logic         s_ov, s_ir, s_c, s_z, s_v, last_acc;
  logic [W-1:0] s_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model from the opcode definitions using plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] av,
                                         input logic [W-1:0] bv);
    longint full = longint'(1) << W;
    longint half = full / 2;
    longint ua = longint'(av);
    longint ub = longint'(bv);
    longint sa = (ua >= half) ? ua - full : ua;
    longint sb = (ub >= half) ? ub - full : ub;
    longint r = 0;
    longint s = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic [W-1:0] rr;
    case (op)
      4'h0: begin r = ua + ub; c = (r >= full); s = sa + sb; v = (s >= half) || (s < -half); end
      4'h1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s >= half) || (s < -half); end
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: r = ua ^ ub;
      4'h5: r = (full - 1) - ua;
      4'h6: begin r = ua * 2; c = (ua >= half); end
      4'h7: begin r = ua / 2; c = (ua % 2) != 0; end
      4'h8: begin r = ua * 2 + ((ua >= half) ? 1 : 0); c = (ua >= half); end
      4'h9: begin r = ua / 2 + (ua % 2) * half; c = (ua % 2) != 0; end
      4'hA: begin r = ua + 1; c = (ua == full - 1); v = (sa == half - 1); end
      4'hB: begin r = ua - 1; c = (ua == 0); v = (sa == -half); end
      4'hC: r = (ua < ub) ? ua : ub;
      4'hD: r = (ua > ub) ? ua : ub;
      4'hE: r = (ua == ub) ? 1 : 0;
`ifdef ALU_MULT_EN
      4'hF: begin r = ua * ub; c = (r >= full); end
`else
      4'hF: r = ua;
`endif
      default: r = 0;
    endcase
    r = r & (full - 1);
    rr = r[W-1:0];
    return {c, (r == 0), v, rr};
  endfunction

  // One clock: sample at negedge, book transfers, then step past posedge.
  task automatic tick();
    @(negedge clock);
    s_ov = out_valid; s_ir = in_ready; s_res = result;
    s_c = carry_out; s_z = zero; s_v = overflow;
    check("in_ready_rule", 32'(s_ir), 32'(!s_ov || out_ready));
    if (s_ov) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output got=%0h exp=none", s_res);
      end
      if (exp_q.size() != 0) begin
        check("result", 32'(s_res), 32'(exp_q[0][W-1:0]));
        check("carry", 32'(s_c), 32'(exp_q[0][W+2]));
        check("zero", 32'(s_z), 32'(exp_q[0][W+1]));
        check("overflow", 32'(s_v), 32'(exp_q[0][W]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          out_cnt++;
        end
      end
    end
    last_acc = in_valid && s_ir;
    if (last_acc) exp_q.push_back(model(selection, a, b));
    @(posedge clock);
    #1;
  endtask

  // Single transaction into an empty pipe; checks latency and literal results.
  task automatic send_dir(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] er, input logic ec, input logic ez, input logic ev);
    int lat;
    in_valid = 1'b1; a = av; b = bv; selection = op; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      lat++;
      if (s_ov) break;
    end
    check("latency", 32'(lat), 32'd2);
    check("dir_result", 32'(s_res), 32'(er));
    check("dir_carry", 32'(s_c), 32'(ec));
    check("dir_zero", 32'(s_z), 32'(ez));
    check("dir_overflow", 32'(s_v), 32'(ev));
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ba[4];
    logic [W-1:0] bb[4];
    int idx;
    int cnt0;
    logic drop_seen;
    logic have_item;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({carry_out, zero, overflow}), 32'd0);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // directed cases
    send_dir(4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    send_dir(4'h1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    send_dir(4'h1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0);
    send_dir(4'h6, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    send_dir(4'h9, 8'h81, 8'h00, 8'hC0, 1'b1, 1'b0, 1'b0);
    send_dir(4'h7, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);
    send_dir(4'hA, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1);
    send_dir(4'hB, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
`ifdef ALU_MULT_EN
    send_dir(4'hF, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
`else
    send_dir(4'hF, 8'h10, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
`endif
    drain();

    // back-pressure: 4 ADDs, consumer stalls for 3 cycles mid-stream
    for (int i = 0; i < 4; i++) begin
      ba[i] = W'($urandom_range(0, 255));
      bb[i] = W'($urandom_range(0, 255));
    end
    idx = 0; cnt0 = out_cnt; drop_seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin a = ba[idx]; b = bb[idx]; end
      selection = 4'h0;
      out_ready = !(c >= 2 && c <= 4);
      tick();
      if (!s_ir) drop_seen = 1'b1;
      if (last_acc) idx++;
    end
    check("bp_in_ready_dropped", 32'(drop_seen), 32'd1);
    check("bp_delivered", 32'(out_cnt - cnt0), 32'd4);
    drain();

    // reset with two transactions in flight
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h12; b = 8'h34; selection = 4'h0;
    tick();
    a = 8'h56; b = 8'h01; selection = 4'h1;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs", 32'({result, carry_out, zero, overflow}), 32'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    drain();

    // randomized traffic
    have_item = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!have_item && $urandom_range(0, 3) != 0) begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        selection = 4'($urandom_range(0, 15));
        have_item = 1'b1;
      end
      in_valid = have_item;
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      if (last_acc) have_item = 1'b0;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's simple 8-bit ALU.
- Adds valid/ready handshakes on input and output, back-pressure, extended opcodes, and zero/overflow flags.
- Sits between the stimulus/issue logic and the result consumer. At most 2 transactions in flight.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 4).
- SEL_W, 4, opcode width; must be 4. Opcodes are defined in the package.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all pipeline state
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- selection  input  SEL_W  opcode
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- carry_out  output  1  carry / borrow / shifted-out bit
- zero  output  1  result == 0
- overflow  output  1  signed overflow (ADD, SUB, INC, DEC only; otherwise 0)

Behaviour:
- Reset (async assert): out_valid=0, result=0, carry_out=0, zero=0, overflow=0, both stage-valid bits=0. After reset, in_ready=1 from the first cycle.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Pipeline:
  - S1 registers a, b and selection.
  - S2 registers the combinational core outputs: result, carry, zero, overflow.
- Advance rule: global enable adv = !out_valid || out_ready. in_ready = adv.
  - When adv=1: S1 loads inputs, s1_valid <= in_valid; S2 loads the core output of S1, out_valid <= s1_valid.
  - When adv=0: all stages hold their values.
- Latency: result appears 2 cycles after acceptance with no stall. Throughput is 1 per cycle. out_valid=1 with out_ready=0 holds all outputs stable.
- Bubbles: a cycle with in_valid=0 propagates a bubble; S2 data is don't-care but out_valid=0.
- Opcodes (A=a, B=b, unsigned unless noted):
  - 0 ADD: {carry,result}=A+B
  - 1 SUB: result=A-B, carry=borrow (A<B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A by 1, carry=A[MSB]
  - 7 SHR A by 1 (logical), carry=A[0]
  - 8 ROL A by 1, carry=A[MSB]
  - 9 ROR A by 1, carry=A[0]
  - A INC A, carry on wrap all-ones->0
  - B DEC A, carry (borrow) on 0->all-ones
  - C MIN unsigned
  - D MAX unsigned
  - E EQ: result=1 if A==B else 0
  - F PASS A
- Carry for ops 2,3,4,5,C,D,E,F = 0.
- Overflow: ADD: A,B same sign and result sign differs. SUB: signs differ and result sign != A sign. INC: A = 0111..1. DEC: A = 1000..0.
- Simultaneous events: with out_valid=1 and out_ready=1 and in_valid=1, the output is consumed and a new input accepted in the same cycle; no bubble.
- Reset mid-operation drops both in-flight transactions with no output.

Optional Feature:
- Macro ALU_MULT_EN.
- Defined: opcode F becomes MUL. result = low WIDTH bits of A*B (unsigned); carry_out = 1 if the high WIDTH bits are nonzero.
- Undefined: opcode F is PASS A. No multiplier is inferred.
- Latency is unchanged in both cases.

Decomposition:
- Package alu_pkg holds:
  - the opcode enum (OP_ADD..OP_PASS/OP_MUL, 4 bits)
  - the flags struct {carry, zero, overflow}
- Sub-module alu_core: purely combinational, parametrised by WIDTH. Maps (a, b, selection) to (result, flags). Instantiated between S1 and S2.

Test Plan:
- Reset: assert reset mid-stream with 2 in flight -> outputs all 0, out_valid=0, no stale result appears after deassert; in_ready=1.
- ADD: a=0xFF, b=0x01, op 0 -> result 0x00, carry 1, zero 1, overflow 0, exactly 2 cycles after acceptance.
- SUB: a=0x80, b=0x01, op 1 -> result 0x7F, carry 0, overflow 1. Then a=0x05, b=0x07 -> result 0xFE, carry 1.
- Shift/rotate: a=0x81; SHL -> 0x02, carry 1; ROR -> 0xC0, carry 1; SHR -> 0x40, carry 1.
- Back-pressure: stream 4 ADDs back-to-back with out_ready low for 3 cycles mid-stream -> in_ready drops, outputs held stable, all 4 results delivered in order with none lost or duplicated.
- ALU_MULT_EN: a=0x10, b=0x10, op F -> result 0x00, carry 1. Without the macro, the same stimulus gives result 0x10, carry 0.
